demux_mem_1x2_8bits: RTL and testbench

//   Receive-side counterpart of the 2x1 memory mux: takes a single interleaved

---
 rtl/demux_mem_1x2_8bits.sv | 153 +++++++++++++++
 tb/tb_demux_mem_1x2_8bits.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_mem_1x2_8bits.sv
// ---------------------------------------------------------------------------
// demux_mem_1x2_8bits
//
// Purpose:
//   Splits a single interleaved byte stream (lane 0, lane 1, lane 0, ...)
//   back into two lanes. Each lane has its own first-word-fall-through FIFO,
//   so the two consumers drain their lanes independently. The input side uses
//   a ready/valid handshake. A byte held off by a full lane keeps its lane, so
//   the interleaving order is never broken.
//
// Ports:
//   clk        in   1       system clock, all logic on posedge
//   reset      in   1       synchronous, active-high reset
//   data_in    in   DATA_W  interleaved input byte
//   valid_in   in   1       data_in is valid this cycle
//   ready_in   out  1       block accepts data_in this cycle
//   data_out0  out  DATA_W  head of lane-0 FIFO (0 when empty)
//   valid0     out  1       lane 0 non-empty
//   pop0       in   1       consume lane-0 head
//   data_out1  out  DATA_W  head of lane-1 FIFO (0 when empty)
//   valid1     out  1       lane 1 non-empty
//   pop1       in   1       consume lane-1 head
//   lane_sel   out  1       lane that receives the next accepted byte
// ---------------------------------------------------------------------------
module demux_mem_1x2_8bits #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid0,
    input  logic              pop0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid1,
    input  logic              pop1,
    output logic              lane_sel
);

    localparam int              NUM_LANES  = 2;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Per-lane FIFO state
    logic [ADDR_W-1:0] wr_ptr_q [NUM_LANES];
    logic [ADDR_W-1:0] wr_ptr_d [NUM_LANES];
    logic [ADDR_W-1:0] rd_ptr_q [NUM_LANES];
    logic [ADDR_W-1:0] rd_ptr_d [NUM_LANES];
    logic [ADDR_W:0]   count_q  [NUM_LANES];
    logic [ADDR_W:0]   count_d  [NUM_LANES];
    logic [DATA_W-1:0] mem      [NUM_LANES][DEPTH];

    logic lane_sel_q;
    logic lane_sel_d;

    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] empty;
    logic [NUM_LANES-1:0] pop_req;
    logic [NUM_LANES-1:0] push_lane;
    logic [NUM_LANES-1:0] pop_lane;
    logic                 push;

    // Status flags come only from registered counts, so ready_in never
    // depends combinationally on pop0/pop1.
    always_comb begin
        pop_req = {pop1, pop0};
        for (int i = 0; i < NUM_LANES; i++) begin
            full[i]  = (count_q[i] == FULL_COUNT);
            empty[i] = (count_q[i] == '0);
        end
    end

    assign ready_in = ~full[lane_sel_q];
    assign push     = valid_in & ready_in;

    // NOTE: every always_comb output gets a default before any conditional
    //       update; a path that leaves a variable unassigned infers a latch.
    always_comb begin
        lane_sel_d = lane_sel_q;
        push_lane  = '0;
        pop_lane   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
        end

        if (push) begin
            lane_sel_d = ~lane_sel_q;
        end

        for (int i = 0; i < NUM_LANES; i++) begin
            push_lane[i] = push & (int'(lane_sel_q) == i);
            // Pops on an empty lane are dropped here, so pointers never underflow.
            pop_lane[i]  = pop_req[i] & ~empty[i];

            if (push_lane[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + ADDR_W'(1);
            end
            if (pop_lane[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + ADDR_W'(1);
            end

            // Simultaneous push and pop on one lane leaves the count unchanged.
            unique case ({push_lane[i], pop_lane[i]})
                2'b10:   count_d[i] = count_q[i] + (ADDR_W + 1)'(1);
                2'b01:   count_d[i] = count_q[i] - (ADDR_W + 1)'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    //       its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_sel_q <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            lane_sel_q <= lane_sel_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only read
    //       after it has been written, and empty lanes force their output to 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push_lane[i] && !reset) begin
                mem[i][wr_ptr_q[i]] <= data_in;
            end
        end
    end

    // First-word-fall-through heads
    assign data_out0 = empty[0] ? '0 : mem[0][rd_ptr_q[0]];
    assign data_out1 = empty[1] ? '0 : mem[1][rd_ptr_q[1]];
    assign valid0    = ~empty[0];
    assign valid1    = ~empty[1];
    assign lane_sel  = lane_sel_q;

endmodule

// File: tb/tb_demux_mem_1x2_8bits.sv
// ---------------------------------------------------------------------------
// tb_demux_mem_1x2_8bits
//
// Directed bench for demux_mem_1x2_8bits. Inputs change 1 time unit after the
// rising edge and outputs are sampled at that same point, well away from the
// next active edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_demux_mem_1x2_8bits;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] data_out0;
    logic       valid0;
    logic       pop0;
    logic [7:0] data_out1;
    logic       valid1;
    logic       pop1;
    logic       lane_sel;

    int checks = 0;
    int errors = 0;

    demux_mem_1x2_8bits dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out0 (data_out0),
        .valid0    (valid0),
        .pop0      (pop0),
        .data_out1 (data_out1),
        .valid1    (valid1),
        .pop1      (pop1),
        .lane_sel  (lane_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then return all strobes to idle.
    task automatic tick(input logic v, input logic [7:0] d, input logic p0, input logic p1);
        valid_in = v;
        data_in  = d;
        pop0     = p0;
        pop1     = p1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        pop0     = 1'b0;
        pop1     = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        pop0     = 1'b0;
        pop1     = 1'b0;

        // 1: reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid0", valid0, 1'b0);
        check("rst_valid1", valid1, 1'b0);
        check("rst_data0", data_out0, 8'h00);
        check("rst_data1", data_out1, 8'h00);
        check("rst_lane_sel", lane_sel, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", ready_in, 1'b1);

        // 2: back-to-back stream with both consumers always popping
        for (int b = 0; b < 8; b++) begin
            check("s2_ready", ready_in, 1'b1);
            tick(1'b1, 8'(b), 1'b1, 1'b1);
            if (b % 2 == 0) begin
                check("s2_lane0_data", data_out0, 32'(b));
                check("s2_lane0_valid", valid0, 1'b1);
            end else begin
                check("s2_lane1_data", data_out1, 32'(b));
                check("s2_lane1_valid", valid1, 1'b1);
            end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        check("s2_end_valid0", valid0, 1'b0);
        check("s2_end_valid1", valid1, 1'b0);
        check("s2_end_lane_sel", lane_sel, 1'b0);

        // 3: fill both lanes, 0x18 is held off until lane 0 is popped
        for (int b = 8'h10; b < 8'h18; b++) begin
            check("s3_fill_ready", ready_in, 1'b1);
            tick(1'b1, 8'(b), 1'b0, 1'b0);
        end
        valid_in = 1'b1;
        data_in  = 8'h18;
        check("s3_full_ready", ready_in, 1'b0);
        check("s3_full_lane_sel", lane_sel, 1'b0);
        @(posedge clk);
        #1;
        check("s3_hold_ready", ready_in, 1'b0);
        check("s3_hold_head0", data_out0, 8'h10);
        pop0 = 1'b1;
        @(posedge clk);
        #1;
        pop0 = 1'b0;
        check("s3_after_pop_ready", ready_in, 1'b1);
        check("s3_after_pop_head0", data_out0, 8'h12);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("s3_accept_lane_sel", lane_sel, 1'b1);
        check("s3_accept_head0", data_out0, 8'h12);
        for (int k = 0; k < 4; k++) begin
            check("s3_drain_head0", data_out0, 32'(8'h12 + 2 * k));
            check("s3_drain_head1", data_out1, 32'(8'h11 + 2 * k));
            tick(1'b0, 8'h00, 1'b1, 1'b1);
        end
        check("s3_drained_valid0", valid0, 1'b0);
        check("s3_drained_valid1", valid1, 1'b0);

        // 4: push+pop on lane 1 in the same cycle, across the pointer wrap
        check("s4_start_lane_sel", lane_sel, 1'b1);
        for (int b = 8'h20; b < 8'h26; b++) begin
            tick(1'b1, 8'(b), 1'b0, 1'b0);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("s4_two_head1", data_out1, 8'h22);
        tick(1'b1, 8'h26, 1'b0, 1'b1);
        check("s4_pp1_head1", data_out1, 8'h24);
        check("s4_pp1_valid1", valid1, 1'b1);
        tick(1'b1, 8'h27, 1'b0, 1'b0);
        tick(1'b1, 8'h28, 1'b0, 1'b1);
        check("s4_pp2_head1", data_out1, 8'h26);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("s4_drain_head1", data_out1, 8'h28);
        check("s4_drain_valid1", valid1, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("s4_lane1_empty", valid1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("s4_drain_head0", data_out0, 32'(8'h21 + 2 * k));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("s4_lane0_empty", valid0, 1'b0);
        check("s4_end_lane_sel", lane_sel, 1'b0);

        // 5: pops on empty lanes are ignored
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b1);
            check("s5_empty_valid0", valid0, 1'b0);
            check("s5_empty_valid1", valid1, 1'b0);
            check("s5_empty_data0", data_out0, 8'h00);
        end
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        check("s5_a5_data0", data_out0, 8'hA5);
        check("s5_a5_valid0", valid0, 1'b1);
        check("s5_a5_valid1", valid1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("s5_a5_popped", valid0, 1'b0);

        // 6: reset in the middle of a burst
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("s6_pre_lane_sel", lane_sel, 1'b1);
        tick(1'b1, 8'h3F, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        for (int b = 8'h30; b < 8'h35; b++) begin
            tick(1'b1, 8'(b), 1'b0, 1'b0);
        end
        check("s6_burst_head0", data_out0, 8'h30);
        check("s6_burst_lane_sel", lane_sel, 1'b1);
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'h35;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        check("s6_rst_valid0", valid0, 1'b0);
        check("s6_rst_valid1", valid1, 1'b0);
        check("s6_rst_data0", data_out0, 8'h00);
        check("s6_rst_lane_sel", lane_sel, 1'b0);
        tick(1'b1, 8'h40, 1'b0, 1'b0);
        check("s6_restart_head0", data_out0, 8'h40);
        check("s6_restart_valid1", valid1, 1'b0);
        tick(1'b1, 8'h41, 1'b0, 1'b0);
        check("s6_restart_head1", data_out1, 8'h41);
        check("s6_restart_lane_sel", lane_sel, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
